// File: rtl/stopwatch_button_ctrl.sv
// Front-panel button conditioner: two debounced channels (start/stop, clear)
// feeding a run-state FSM that emits single-cycle start/stop/clear pulses.
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic start,
  output logic stop,
  output logic clear,
  output logic running
);

  localparam int NUM_CH = 2;
  localparam int CH_SS  = 0;
  localparam int CH_CLR = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NUM_CH-1:0]    raw;
  logic [NUM_CH-1:0]    s1_reg;
  logic [NUM_CH-1:0]    s2_reg;
  logic [NUM_CH-1:0]    st_reg;
  logic [NUM_CH-1:0]    st_next;
  logic [CNT_WIDTH-1:0] cnt_reg  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_CH];
  logic [NUM_CH-1:0]    press;

  state_t state_reg;
  logic   start_reg;
  logic   stop_reg;
  logic   clear_reg;

  assign raw[CH_SS]  = btn_ss;
  assign raw[CH_CLR] = btn_clr;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      always_ff @(posedge clk) begin
        if (!resetn) begin
          s1_reg[gi]  <= 1'b0;
          s2_reg[gi]  <= 1'b0;
          st_reg[gi]  <= 1'b0;
          cnt_reg[gi] <= '0;
        end else begin
          s1_reg[gi]  <= raw[gi];
          s2_reg[gi]  <= s1_reg[gi];
          st_reg[gi]  <= st_next[gi];
          cnt_reg[gi] <= cnt_next[gi];
        end
      end

      // Press is decoded from the accepting transition itself, so the FSM
      // registers its pulse on the same edge that updates the accepted level.
      always_comb begin
        st_next[gi]  = st_reg[gi];
        cnt_next[gi] = '0;
        press[gi]    = 1'b0;
        if (s2_reg[gi] != st_reg[gi]) begin
          if (cnt_reg[gi] == CNT_LAST) begin
            st_next[gi] = s2_reg[gi];
            press[gi]   = s2_reg[gi];
          end else begin
            cnt_next[gi] = cnt_reg[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Clear has priority; a coincident start/stop press is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      clear_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      clear_reg <= 1'b0;
      if (press[CH_CLR]) begin
        clear_reg <= 1'b1;
        state_reg <= IDLE;
      end else if (press[CH_SS]) begin
        case (state_reg)
          IDLE: begin
            start_reg <= 1'b1;
            state_reg <= RUN;
          end
          default: begin
            stop_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign start   = start_reg;
  assign stop    = stop_reg;
  assign clear   = clear_reg;
  assign running = (state_reg == RUN);

endmodule
